sipo_loader: RTL and testbench
==============================

# sipo_loader

Serial-in, parallel-out word assembler that sits directly upstream of the team's parallel-load `register` block. It collects `WIDTH` serial bits (MSB first) under a valid qualifier and presents the assembled word on `data_out`. It pulses `load` for exactly one cycle so the downstream register captures the word at the following clock edge. A small FSM handles start, abort and reset.

## Interface
- `WIDTH`, default 8: word width in bits; must be at least 2.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: reset, synchronous and active-high; sampled on `clk` rising edge.
- `start`  in  1: begins a frame; honoured only in IDLE.
- `abort`  in  1: discards the frame in progress; honoured only in SHIFT.
- `ser_valid`  in  1: `ser_in` carries a bit this cycle; honoured only in SHIFT.
- `ser_in`  in  1: serial data bit, MSB first.
- `data_out`  out  WIDTH: last completed word; connects to the downstream `data_in`.
- `load`  out  1: one-cycle pulse marking `data_out` newly valid; connects to the downstream `load`.
- `busy`  out  1: high while in SHIFT or LOAD.

## Operation
- State register: IDLE, SHIFT, LOAD.
- Internal `shift_reg` is WIDTH bits. `bit_cnt` is $clog2(WIDTH) bits and counts 0..WIDTH-1.
- **Reset** (`rst`=1 at an edge), which overrides every other input:
  - state goes to IDLE; `shift_reg`, `bit_cnt` and `data_out` are cleared to 0.
  - `load`=0 and `busy`=0 in the following cycle.
- **IDLE**:
  - `start`=1 moves to SHIFT and clears `bit_cnt` and `shift_reg`.
  - `ser_valid`, `ser_in` and `abort` are ignored.
- **SHIFT**, with checks in priority order:
  - `abort`=1 moves to IDLE. `data_out` is unchanged, no `load` pulse is issued, and any `ser_valid` in the same cycle is discarded.
  - `ser_valid`=1 with `bit_cnt` < WIDTH-1: `shift_reg` <= {`shift_reg`[WIDTH-2:0], `ser_in`}, and `bit_cnt` increments.
  - `ser_valid`=1 with `bit_cnt` = WIDTH-1: `data_out` <= {`shift_reg`[WIDTH-2:0], `ser_in`}, and the state moves to LOAD.
  - `ser_valid`=0: hold. Gaps of any length are allowed.
  - `start` is ignored.
- **LOAD**:
  - `load`=1 for this single cycle, then the state unconditionally returns to IDLE.
  - `start`, `abort` and `ser_valid` are ignored.
- `data_out` changes only on entry to LOAD or on reset. It holds the previous word at all other times, including through aborts.
- `load` and `busy` are decoded from the state register (Moore outputs).
  - `load` is high only in LOAD.
  - `busy` is high in SHIFT and LOAD.

## Timing
- `start` sampled at edge E0: `busy` rises after E0, and the first bit can be sampled at edge E1.
- With `ser_valid` held high continuously, bits are sampled at edges E1..E_WIDTH.
  - `data_out` and `load` update at edge E_WIDTH; `load` is high for the cycle E_WIDTH..E_WIDTH+1.
  - `busy` falls after edge E_WIDTH+1.
  - Minimum frame is WIDTH+2 cycles from `start` to the next accepted `start`.
- Each idle cycle of `ser_valid` in SHIFT delays `load` by exactly one cycle.
- The downstream register captures `data_out` at edge E_WIDTH+1. `data_out` is stable from E_WIDTH until the next LOAD entry.
- `rst` in any state takes effect at that edge. If `rst` is asserted in the LOAD cycle, `data_out` reads 0 in the following cycle.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with `start`=1 and `ser_valid`=1 -> `data_out`=0x00, `load`=0, `busy`=0 throughout and after release.
- Contiguous frame: `start`, then bits 0,1,0,1,0,1,0,1 with `ser_valid`=1 on consecutive cycles.
  - Required: `load` high for exactly one cycle, 8 edges after the edge that sampled `start`, with `data_out`=0x55.
  - Required: the downstream register output reads 0x55 one edge later.
- Gapped frame: 0xAA with `ser_valid`=0 for 3 cycles after bit 4 -> `data_out`=0xAA, and `load` arrives exactly 3 cycles later than in the contiguous case.
- Abort, then recovery:
  - Abort after 5 bits of 0x00 while `ser_valid`=1 -> no `load`, `data_out` stays 0xAA, `busy`=0 next cycle.
  - A following 0xFF frame -> `data_out`=0xFF with one `load` pulse.
- Reset mid-frame: `rst`=1 after 3 bits -> `data_out`=0x00, state IDLE, no `load`. The next frame 0x0F completes correctly.
- Ignored inputs:
  - `start` held high for a whole frame -> one `load` per frame, and a new frame begins only from IDLE.
  - `ser_valid` toggling in IDLE -> no change to `data_out`.

Source files
------------

// File: rtl/sipo_loader.sv
// Serial-in, parallel-out word assembler. It gathers WIDTH bits MSB first and
// pulses load for one cycle so a downstream parallel register can capture data_out.
module sipo_loader #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             ser_valid,
  input  logic             ser_in,
  output logic [WIDTH-1:0] data_out,
  output logic             load,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_reg_q, shift_reg_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             load_q, busy_q;

  always_comb begin
    state_d     = state_q;
    shift_reg_d = shift_reg_q;
    data_out_d  = data_out_q;
    bit_cnt_d   = bit_cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = SHIFT;
          bit_cnt_d   = '0;
          shift_reg_d = '0;
        end
      end
      SHIFT: begin
        // Abort wins over a bit arriving in the same cycle.
        if (abort) begin
          state_d = IDLE;
        end else if (ser_valid) begin
          if (bit_cnt_q == LAST_BIT) begin
            data_out_d = {shift_reg_q[WIDTH-2:0], ser_in};
            state_d    = LOAD;
          end else begin
            shift_reg_d = {shift_reg_q[WIDTH-2:0], ser_in};
            bit_cnt_d   = bit_cnt_q + CW'(1);
          end
        end
      end
      LOAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they match a Moore decode of state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_reg_q <= '0;
      data_out_q  <= '0;
      bit_cnt_q   <= '0;
      load_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_reg_q <= shift_reg_d;
      data_out_q  <= data_out_d;
      bit_cnt_q   <= bit_cnt_d;
      load_q      <= (state_d == LOAD);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign data_out = data_out_q;
  assign load     = load_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_sipo_loader.sv
// Self-checking bench for sipo_loader: frames are scoreboarded on start and
// checked when load appears, alongside a model of the downstream register.
module tb_sipo_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       ser_valid = 1'b0;
  logic       ser_in = 1'b0;
  logic [7:0] data_out;
  logic       load;
  logic       busy;

  int         n_checks = 0;
  int         n_fail = 0;
  int         load_cnt = 0;
  logic [7:0] sb[$];
  logic [7:0] down_q;

  sipo_loader #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .ser_valid(ser_valid),
    .ser_in   (ser_in),
    .data_out (data_out),
    .load     (load),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Downstream parallel-load register and load-pulse counter.
  always @(posedge clk) begin
    if (rst) down_q <= 8'h00;
    else if (load === 1'b1) down_q <= data_out;
    if (load === 1'b1) load_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input logic [7:0] word, input int gap_at, input int gap_len,
                           input logic hold_start, input string name);
    int lat;
    int base_loads;
    logic [7:0] exp;
    sb.push_back(word);
    base_loads = load_cnt;
    start = 1'b1;
    step();
    lat = 0;
    if (!hold_start) start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL %s busy_after_start: got %b want 1", name, busy);
    end
    for (int i = 0; i < 8; i++) begin
      if (i == gap_at) begin
        ser_valid = 1'b0;
        repeat (gap_len) begin step(); lat++; end
      end
      ser_valid = 1'b1;
      ser_in = word[7-i];
      step();
      lat++;
      if (i < 7) begin
        n_checks++;
        if (load !== 1'b0) begin
          n_fail++; $display("FAIL %s early_load bit%0d: got %b want 0", name, i, load);
        end
      end
    end
    ser_valid = 1'b0;
    while (load !== 1'b1 && lat < 40) begin step(); lat++; end
    exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
    n_checks++;
    if (load !== 1'b1) begin
      n_fail++; $display("FAIL %s load_timeout: got no load within %0d edges want %0d", name, lat, 8 + gap_len);
    end else begin
      $display("frame %s: data_out=%02h exp=%02h latency=%0d", name, data_out, exp, lat);
      n_checks++;
      if (data_out !== exp) begin
        n_fail++; $display("FAIL %s data_out: got %02h want %02h", name, data_out, exp);
      end
      n_checks++;
      if (lat != 8 + gap_len) begin
        n_fail++; $display("FAIL %s load_latency: got %0d want %0d", name, lat, 8 + gap_len);
      end
    end
    step();
    n_checks++;
    if (load !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL %s after_load load/busy: got %b/%b want 0/0", name, load, busy);
    end
    n_checks++;
    if (down_q !== word) begin
      n_fail++; $display("FAIL %s downstream_reg: got %02h want %02h", name, down_q, word);
    end
    n_checks++;
    if (load_cnt - base_loads != 1) begin
      n_fail++; $display("FAIL %s load_pulses: got %0d want 1", name, load_cnt - base_loads);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; ser_valid = 1'b1; ser_in = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      n_checks++;
      if (data_out !== 8'h00 || load !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL reset_hold%0d data/load/busy: got %02h/%b/%b want 00/0/0", c, data_out, load, busy);
      end
    end
    rst = 1'b0; start = 1'b0; ser_valid = 1'b0;
    step();
    n_checks++;
    if (data_out !== 8'h00 || load !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_release data/load/busy: got %02h/%b/%b want 00/0/0", data_out, load, busy);
    end
    $display("reset: data_out=%02h load=%b busy=%b", data_out, load, busy);
  endtask

  task automatic test_contiguous();
    run_frame(8'h55, -1, 0, 1'b0, "contig_55");
  endtask

  task automatic test_gapped();
    run_frame(8'hAA, 4, 3, 1'b0, "gapped_AA");
  endtask

  task automatic test_abort();
    int base_loads;
    base_loads = load_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ser_valid = 1'b1; ser_in = 1'b0;
      step();
    end
    abort = 1'b1; ser_valid = 1'b1; ser_in = 1'b1;
    step();
    abort = 1'b0; ser_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || load !== 1'b0) begin
      n_fail++; $display("FAIL abort busy/load: got %b/%b want 0/0", busy, load);
    end
    repeat (3) step();
    n_checks++;
    if (data_out !== 8'hAA) begin
      n_fail++; $display("FAIL abort data_out: got %02h want AA", data_out);
    end
    n_checks++;
    if (load_cnt != base_loads) begin
      n_fail++; $display("FAIL abort load_pulses: got %0d want 0", load_cnt - base_loads);
    end
    $display("abort: data_out=%02h busy=%b", data_out, busy);
    run_frame(8'hFF, -1, 0, 1'b0, "after_abort_FF");
  endtask

  task automatic test_reset_midframe();
    int base_loads;
    base_loads = load_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ser_valid = 1'b1; ser_in = i[0];
      step();
    end
    ser_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (data_out !== 8'h00 || busy !== 1'b0 || load !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid data/busy/load: got %02h/%b/%b want 00/0/0", data_out, busy, load);
    end
    step();
    n_checks++;
    if (load_cnt != base_loads) begin
      n_fail++; $display("FAIL reset_mid load_pulses: got %0d want 0", load_cnt - base_loads);
    end
    $display("reset_mid: data_out=%02h busy=%b", data_out, busy);
    run_frame(8'h0F, -1, 0, 1'b0, "after_reset_0F");
  endtask

  task automatic test_start_held();
    run_frame(8'h3C, -1, 0, 1'b1, "start_held_3C");
    step();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL start_held restart_from_idle busy: got %b want 1", busy);
    end
    abort = 1'b1;
    step();
    abort = 1'b0; start = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || data_out !== 8'h3C) begin
      n_fail++; $display("FAIL start_held abort busy/data: got %b/%02h want 0/3C", busy, data_out);
    end
    $display("start_held: restart then abort, data_out=%02h", data_out);
  endtask

  task automatic test_idle_ignored();
    int base_loads;
    base_loads = load_cnt;
    for (int c = 0; c < 6; c++) begin
      ser_valid = c[0]; ser_in = 1'b1; abort = c[1];
      step();
      n_checks++;
      if (data_out !== 8'h3C || busy !== 1'b0) begin
        n_fail++; $display("FAIL idle_toggle%0d data/busy: got %02h/%b want 3C/0", c, data_out, busy);
      end
    end
    ser_valid = 1'b0; abort = 1'b0;
    step();
    n_checks++;
    if (load_cnt != base_loads) begin
      n_fail++; $display("FAIL idle_toggle load_pulses: got %0d want 0", load_cnt - base_loads);
    end
    $display("idle_toggle: data_out=%02h", data_out);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_contiguous();
    test_gapped();
    test_abort();
    test_reset_midframe();
    test_start_held();
    test_idle_ignored();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
